seq_chunk_adder: RTL and testbench



---
 rtl/seq_chunk_adder.sv | 107 ++++++++++
 tb/tb_seq_chunk_adder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle ripple-carry adder/subtractor: adds CHUNK bits per clock with a
// registered inter-chunk carry and valid/ready handshakes on both sides.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;

  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_msb_cin;

  // Slice of the current chunk; the carry into its top bit is recovered from
  // the sum bit, which works for any CHUNK including 1.
  always_comb begin
    chunk_a                  = a_q[idx*CHUNK +: CHUNK];
    chunk_b                  = b_q[idx*CHUNK +: CHUNK];
    {chunk_cout, chunk_sum}  = {1'b0, chunk_a} + {1'b0, chunk_b}
                             + {{CHUNK{1'b0}}, carry_q};
    chunk_msb_cin            = chunk_sum[CHUNK-1] ^ chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1];
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; operand registers are reset too so no X can
  // reach sum after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            carry_q  <= sub ? 1'b1 : c_in;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[idx*CHUNK +: CHUNK] <= chunk_sum;
          carry_q                 <= chunk_cout;
          if (idx == LAST_IDX) begin
            c_out     <= chunk_cout;
            ovf       <= chunk_msb_cin ^ chunk_cout;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // Handoff returns to IDLE; a new accept needs a further edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench: three adder instances (CHUNK=4, 16, 1) driven in lockstep
// and checked against a scoreboard of expected results.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic        c_in;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  in_ready;
  logic [2:0]  out_valid;
  logic [2:0]  c_out;
  logic [2:0]  ovf;
  logic [15:0] sum [3];

  int lat [3] = '{4, 1, 16};

  typedef struct packed {
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid[0]),
    .out_ready(out_ready), .sum(sum[0]), .c_out(c_out[0]), .ovf(ovf[0])
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid[1]),
    .out_ready(out_ready), .sum(sum[1]), .c_out(c_out[1]), .ovf(ovf[1])
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid[2]),
    .out_ready(out_ready), .sum(sum[2]), .c_out(c_out[2]), .ovf(ovf[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [15:0] s, input logic co, input logic ov);
    exp_t e;
    e.sum   = s;
    e.c_out = co;
    e.ovf   = ov;
    return e;
  endfunction

  // Reference: full-width add on 17 bits, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mc, input logic ms);
    logic [15:0] bb;
    logic [16:0] full;
    exp_t        e;
    bb      = ms ? ~mb : mb;
    full    = {1'b0, ma} + {1'b0, bb} + {16'd0, (ms ? 1'b1 : mc)};
    e.sum   = full[15:0];
    e.c_out = full[16];
    e.ovf   = (ma[15] == bb[15]) && (full[15] != ma[15]);
    return e;
  endfunction

  // Issue one operation to all instances, scramble inputs while they work,
  // hold off the consumer until every instance has finished, then hand off.
  task automatic do_op(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tc, input logic ts, input exp_t e);
    exp_t exp_v;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (in_ready[i] !== 1'b1) begin
        n_errors++;
        $display("FAIL %s in_ready_before dut%0d: got %b want 1", name, i, in_ready[i]);
      end
    end
    a = ta; b = tb_v; c_in = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    sb.push_back(e);
    tick();
    for (int k = 1; k <= 17; k++) begin
      a = 16'($urandom); b = 16'($urandom);
      c_in = 1'($urandom); sub = 1'($urandom); in_valid = 1'($urandom);
      tick();
      exp_v = sb[0];
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (out_valid[i] !== (k >= lat[i])) begin
          n_errors++;
          $display("FAIL %s out_valid dut%0d edge %0d: got %b want %b",
                   name, i, k, out_valid[i], (k >= lat[i]));
        end
        n_checks++;
        if (in_ready[i] !== 1'b0) begin
          n_errors++;
          $display("FAIL %s in_ready_busy dut%0d edge %0d: got %b want 0", name, i, k, in_ready[i]);
        end
        if (k >= lat[i]) begin
          n_checks++;
          if (sum[i] !== exp_v.sum || c_out[i] !== exp_v.c_out || ovf[i] !== exp_v.ovf) begin
            n_errors++;
            $display("FAIL %s result dut%0d edge %0d: got sum=%h c_out=%b ovf=%b want sum=%h c_out=%b ovf=%b",
                     name, i, k, sum[i], c_out[i], ovf[i], exp_v.sum, exp_v.c_out, exp_v.ovf);
          end
        end
      end
    end
    // in_valid held through the handoff edge must not be accepted on that edge.
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1) begin
        n_errors++;
        $display("FAIL %s handoff dut%0d: got out_valid=%b in_ready=%b want 0/1",
                 name, i, out_valid[i], in_ready[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1 || sum[i] !== 16'h0 ||
          c_out[i] !== 1'b0 || ovf[i] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_state dut%0d: got ov=%b ir=%b sum=%h c=%b o=%b want 0/1/0000/0/0",
                 i, out_valid[i], in_ready[i], sum[i], c_out[i], ovf[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    do_op("add_basic", 16'h0003, 16'h0004, 1'b0, 1'b0, mk(16'h0007, 1'b0, 1'b0));
  endtask

  task automatic test_carry();
    do_op("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    do_op("carry_cin", 16'h000F, 16'h0000, 1'b1, 1'b0, mk(16'h0010, 1'b0, 1'b0));
  endtask

  task automatic test_overflow();
    do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1));
  endtask

  task automatic test_subtract();
    do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
    do_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
  endtask

  task automatic test_reset_abort();
    a = 16'h1234; b = 16'h4321; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid[i] !== 1'b0 || in_ready[i] !== 1'b1 || sum[i] !== 16'h0 ||
          c_out[i] !== 1'b0 || ovf[i] !== 1'b0) begin
        n_errors++;
        $display("FAIL abort_state dut%0d: got ov=%b ir=%b sum=%h c=%b o=%b want 0/1/0000/0/0",
                 i, out_valid[i], in_ready[i], sum[i], c_out[i], ovf[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (out_valid !== 3'b000) begin
        n_errors++;
        $display("FAIL abort_no_valid cycle %0d: got %b want 000", k, out_valid);
      end
    end
    do_op("after_abort", 16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0));
  endtask

  task automatic test_random();
    logic [15:0] ra, rb;
    logic        rc, rs;
    for (int n = 0; n < 6; n++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom);  rs = 1'($urandom);
      do_op("random", ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_carry();
    test_overflow();
    test_subtract();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
